// File: rtl/rca_pkg.sv
// rtl/rca_pkg.sv - shared types and helpers for the pipelined ripple-carry accumulator
package rca_pkg;

  typedef enum logic {
    MODE_ADD = 1'b0,
    MODE_ACC = 1'b1
  } mode_e;

  typedef enum logic {
    ST_STREAM   = 1'b0,
    ST_ACC_BUSY = 1'b1
  } state_e;

  function automatic int nseg(input int width, input int seg);
    return width / seg;
  endfunction

endpackage

// File: rtl/rca_pipe_accum_if.sv
// rtl/rca_pipe_accum_if.sv - request/result handshake bundle for rca_pipe_accum
interface rca_pipe_accum_if #(
  parameter int WIDTH = 10
) ();

  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, mode, a, b, cin, clr, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, mode, a, b, cin, clr, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/rca_seg.sv
// rtl/rca_seg.sv - SEG-bit combinational ripple-carry adder slice
module rca_seg #(
  parameter int SEG = 5
) (
  input  logic [SEG-1:0] a_seg,
  input  logic [SEG-1:0] b_seg,
  input  logic           c_in,
  output logic [SEG-1:0] s_seg,
  output logic           c_out
);

  logic [SEG:0] c;

  always_comb begin
    c[0] = c_in;
    for (int i = 0; i < SEG; i++) begin
      s_seg[i] = a_seg[i] ^ b_seg[i] ^ c[i];
      c[i+1]   = (a_seg[i] & b_seg[i]) | (c[i] & (a_seg[i] ^ b_seg[i]));
    end
  end

  assign c_out = c[SEG];

endmodule

// File: rtl/rca_pipe_accum.sv
// rtl/rca_pipe_accum.sv - segmented pipelined ripple-carry adder with saturating accumulator
module rca_pipe_accum
  import rca_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int SEG    = 5,
  parameter bit SAT_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  rca_pipe_accum_if.slave bus
);

  localparam int NSEG = nseg(WIDTH, SEG);
  localparam int LAST = NSEG - 1;

  if (WIDTH % SEG != 0) begin : g_bad_seg
    $error("rca_pipe_accum: WIDTH must be a multiple of SEG");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_eff;
  logic             ovf_q;
  logic             accept, out_fire, wb;

  logic [NSEG-1:0]  v_q, mode_q, kill_q, c_q;
  logic [WIDTH-1:0] a_q [NSEG];
  logic [WIDTH-1:0] b_q [NSEG];
  logic [WIDTH-1:0] s_q [NSEG];

  logic [NSEG-1:0]  v_src, mode_src, kill_src, c_src, co, adv;
  logic [WIDTH-1:0] a_src  [NSEG];
  logic [WIDTH-1:0] b_src  [NSEG];
  logic [WIDTH-1:0] s_base [NSEG];
  logic [WIDTH-1:0] s_d    [NSEG];
  logic [SEG-1:0]   s_seg  [NSEG];

  // A clear in the accept cycle makes the accepted ACC start from zero
  assign acc_eff  = bus.clr ? '0 : acc_q;
  assign accept   = bus.in_valid && bus.in_ready;
  assign out_fire = v_q[LAST] && bus.out_ready;
  assign wb       = out_fire && (mode_q[LAST] == MODE_ACC) && !kill_q[LAST] && !bus.clr;

  always_comb begin
    adv[LAST] = !v_q[LAST] || bus.out_ready;
    for (int k = LAST - 1; k >= 0; k--) begin
      adv[k] = !v_q[k] || adv[k+1];
    end
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign v_src[k]    = accept;
      assign mode_src[k] = bus.mode;
      assign kill_src[k] = 1'b0;
      assign a_src[k]    = bus.a;
      assign b_src[k]    = (bus.mode == MODE_ACC) ? acc_eff : bus.b;
      assign c_src[k]    = (bus.mode == MODE_ACC) ? 1'b0 : bus.cin;
      assign s_base[k]   = '0;
    end else begin : g_body
      assign v_src[k]    = v_q[k-1];
      assign mode_src[k] = mode_q[k-1];
      assign kill_src[k] = kill_q[k-1] | bus.clr;
      assign a_src[k]    = a_q[k-1];
      assign b_src[k]    = b_q[k-1];
      assign c_src[k]    = c_q[k-1];
      assign s_base[k]   = s_q[k-1];
    end

    rca_seg #(.SEG(SEG)) u_seg (
      .a_seg (a_src[k][k*SEG +: SEG]),
      .b_seg (b_src[k][k*SEG +: SEG]),
      .c_in  (c_src[k]),
      .s_seg (s_seg[k]),
      .c_out (co[k])
    );
  end

  always_comb begin
    for (int k = 0; k < NSEG; k++) begin
      s_d[k] = s_base[k];
      s_d[k][k*SEG +: SEG] = s_seg[k];
    end
    if (SAT_EN && (mode_src[LAST] == MODE_ACC) && co[LAST]) begin
      s_d[LAST] = '1;
    end
  end

  // Payload only loads with a valid op so the output holds its last result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= '0;
      mode_q <= '0;
      kill_q <= '0;
      c_q    <= '0;
      for (int k = 0; k < NSEG; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NSEG; k++) begin
        if (adv[k]) begin
          v_q[k] <= v_src[k];
          if (v_src[k]) begin
            mode_q[k] <= mode_src[k];
            kill_q[k] <= kill_src[k];
            c_q[k]    <= co[k];
            a_q[k]    <= a_src[k];
            b_q[k]    <= b_src[k];
            s_q[k]    <= s_d[k];
          end
        end else if (bus.clr) begin
          kill_q[k] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (bus.clr) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else if (wb) begin
      acc_q <= s_q[LAST];
      if (c_q[LAST]) begin
        ovf_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_STREAM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STREAM:   if (accept && (bus.mode == MODE_ACC)) state_d = ST_ACC_BUSY;
      ST_ACC_BUSY: if (out_fire && (mode_q[LAST] == MODE_ACC)) state_d = ST_STREAM;
    endcase
  end

  always_comb begin
    bus.in_ready = 1'b0;
    if (state_q == ST_STREAM) begin
      bus.in_ready = adv[0];
    end
  end

  assign bus.out_valid = v_q[LAST];
  assign bus.sum       = s_q[LAST];
  assign bus.cout      = c_q[LAST];
  assign bus.ovf       = ovf_q;

endmodule
